// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core.
//   * Memory-map constants: text segment bounds and exception handler entry.
//   * Exception codes used by the front end (AdEL on fetch).
//   * The IF/ID pipeline-register bundle and its flushed (bubble) value.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_LAST  = 32'h0000_44E0;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] NOP        = 32'h0000_0000;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exccode;
        logic        bd;
    } if_id_t;

    // Bubble: what IF/ID holds after reset and after any flush.
    localparam if_id_t IF_ID_BUBBLE = '{
        instr:   NOP,
        pc:      32'h0000_0000,
        exccode: EXC_NONE,
        bd:      1'b0
    };

endpackage : mips_pkg

// File: rtl/fetch_addr_check.sv
// ---------------------------------------------------------------------------
// fetch_addr_check
// Combinational word-address legality check. An address faults when it is
// not word aligned or lies outside [ADDR_LO, ADDR_LAST] (inclusive). The
// fault is reported as AdEL; callers on the store path remap the code.
//
// Parameters:
//   ADDR_LO    lowest legal word address
//   ADDR_LAST  highest legal word address (inclusive)
// Ports:
//   addr     in  32  address under test
//   err      out 1   address is illegal
//   exccode  out 5   EXC_ADEL when err, else EXC_NONE
// ---------------------------------------------------------------------------
module fetch_addr_check
    import mips_pkg::*;
#(
    parameter logic [31:0] ADDR_LO   = 32'h0000_3000,
    parameter logic [31:0] ADDR_LAST = 32'h0000_44E0
) (
    input  logic [31:0] addr,
    output logic        err,
    output logic [4:0]  exccode
);

    logic misaligned;
    logic below_range;
    logic above_range;

    assign misaligned  = (addr[1:0] != 2'b00);
    assign below_range = (addr < ADDR_LO);
    assign above_range = (addr > ADDR_LAST);

    assign err     = misaligned | below_range | above_range;
    assign exccode = err ? EXC_ADEL : EXC_NONE;

endmodule : fetch_addr_check

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage. Owns the PC, presents it to the combinational
// instruction memory and captures the returned word into IF/ID.
//
// Next-state priority (highest first):
//   reset > exc_req > stall > eret_req > redirect_valid > sequential (+4)
// exc_req overrides stall so an exception is never lost behind a hazard;
// stall drops redirect/eret because ID re-presents them next cycle.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           hold PC and IF/ID
//   redirect_valid  taken branch / jump in ID, load redirect_pc
//   redirect_pc     branch/jump target
//   id_is_jump      ID holds a branch/jump: next capture is a delay slot
//   exc_req         exception taken downstream: go to HANDLER_PC, flush
//   eret_req        eret in ID: go to epc, flush (no delay slot)
//   epc             return address from CP0
//   pc              fetch address to instruction memory
//   instr_in        instruction word, combinational on pc
//   id_instr        IF/ID instruction (nop on fetch fault)
//   id_pc           IF/ID PC
//   id_pc8          id_pc + 8 (link value)
//   id_exccode      0 = none, 4 = AdEL on fetch
//   id_bd           IF/ID instruction sits in a branch delay slot
// ---------------------------------------------------------------------------
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = mips_pkg::TEXT_BASE,
    parameter logic [31:0] HANDLER_PC = mips_pkg::HANDLER_PC,
    parameter logic [31:0] TEXT_LAST  = mips_pkg::TEXT_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_is_jump,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic [4:0]  id_exccode,
    output logic        id_bd
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    if_id_t      if_id_reg;
    if_id_t      if_id_next;

    logic        fetch_err;
    logic [4:0]  fetch_exccode;
    if_id_t      capture;

    // -----------------------------------------------------------------------
    // Fetch address check on the current PC. Out-of-range or misaligned PCs
    // are never blocked; they simply turn into an AdEL-tagged nop in ID.
    // -----------------------------------------------------------------------
    fetch_addr_check #(
        .ADDR_LO   (TEXT_BASE),
        .ADDR_LAST (TEXT_LAST)
    ) u_fetch_addr_check (
        .addr    (pc_reg),
        .err     (fetch_err),
        .exccode (fetch_exccode)
    );

    // What IF/ID would take if this cycle performs a normal capture.
    always_comb begin
        capture         = IF_ID_BUBBLE;
        capture.instr   = fetch_err ? NOP : instr_in;
        capture.pc      = pc_reg;
        capture.exccode = fetch_exccode;
        capture.bd      = id_is_jump;
    end

    // -----------------------------------------------------------------------
    // Next PC / IF/ID selection. Reset is applied in the register process so
    // it overrides every case here on the same edge.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_next    = pc_reg;
        if_id_next = if_id_reg;

        if (exc_req) begin
            pc_next    = HANDLER_PC;
            if_id_next = IF_ID_BUBBLE;
        end else if (stall) begin
            pc_next    = pc_reg;
            if_id_next = if_id_reg;
        end else if (eret_req) begin
            pc_next    = epc;
            if_id_next = IF_ID_BUBBLE;
        end else if (redirect_valid) begin
            // The word being fetched now is the delay slot: keep it.
            pc_next    = redirect_pc;
            if_id_next = capture;
        end else begin
            pc_next    = pc_reg + 32'd4;
            if_id_next = capture;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= TEXT_BASE;
            if_id_reg <= IF_ID_BUBBLE;
        end else begin
            pc_reg    <= pc_next;
            if_id_reg <= if_id_next;
        end
    end

    assign pc         = pc_reg;
    assign id_instr   = if_id_reg.instr;
    assign id_pc      = if_id_reg.pc;
    assign id_pc8     = if_id_reg.pc + 32'd8;
    assign id_exccode = if_id_reg.exccode;
    assign id_bd      = if_id_reg.bd;

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_is_jump;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [4:0]  id_exccode;
    logic        id_bd;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Instruction memory image: every address returns a distinct nonzero word.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign instr_in = memw(pc);

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_is_jump     (id_is_jump),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .pc             (pc),
        .instr_in       (instr_in),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc8         (id_pc8),
        .id_exccode     (id_exccode),
        .id_bd          (id_bd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every DUT output against an expected architectural state.
    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                           input logic e_nop, input logic [4:0] e_exc, input logic e_bd);
        logic [31:0] e_instr;
        e_instr = e_nop ? 32'h0 : memw(e_idpc);
        chk({tag, ".pc"},       pc,                 e_pc);
        chk({tag, ".id_instr"}, id_instr,           e_instr);
        chk({tag, ".id_pc"},    id_pc,              e_idpc);
        chk({tag, ".id_pc8"},   id_pc8,             e_idpc + 32'd8);
        chk({tag, ".id_exc"},   {27'd0, id_exccode}, {27'd0, e_exc});
        chk({tag, ".id_bd"},    {31'd0, id_bd},     {31'd0, e_bd});
        $display("[TB] %s pc=%h id_pc=%h id_instr=%h exc=%0d bd=%0b", tag, pc, id_pc, id_instr, id_exccode, id_bd);
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        id_is_jump = 0; exc_req = 0; eret_req = 0; epc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        rst, stl, rv, jmp, exc, ert;
        logic [31:0] rpc, epc_v;
        logic [31:0] e_pc, e_idpc;
        logic        e_nop;
        logic [4:0]  e_exc;
        logic        e_bd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string n, input logic rst, input logic stl, input logic rv,
                                input logic [31:0] rpc, input logic jmp, input logic exc,
                                input logic ert, input logic [31:0] ev,
                                input logic [31:0] e_pc, input logic [31:0] e_idpc,
                                input logic e_nop, input logic [4:0] e_exc, input logic e_bd);
        vec_t v;
        v.name = n; v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.jmp = jmp;
        v.exc = exc; v.ert = ert; v.epc_v = ev; v.e_pc = e_pc; v.e_idpc = e_idpc;
        v.e_nop = e_nop; v.e_exc = e_exc; v.e_bd = e_bd;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_idpc, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd;

    function automatic bit fetch_bad(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a);
        return (ua % 4 != 0) || (ua < 64'h3000) || (ua > 64'h44E0);
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pc = 32'h3000; m_idpc = 0; m_instr = 0; m_exc = 0; m_bd = 0;
        end else if (exc_req) begin
            m_pc = 32'h4180; m_idpc = 0; m_instr = 0; m_exc = 0; m_bd = 0;
        end else if (stall) begin
            // nothing moves
        end else if (eret_req) begin
            m_pc = epc; m_idpc = 0; m_instr = 0; m_exc = 0; m_bd = 0;
        end else begin
            m_idpc  = m_pc;
            m_instr = fetch_bad(m_pc) ? 32'h0 : memw(m_pc);
            m_exc   = fetch_bad(m_pc) ? 5'd4 : 5'd0;
            m_bd    = id_is_jump;
            m_pc    = redirect_valid ? redirect_pc : m_pc + 32'd4;
        end
    endtask

    function automatic logic [31:0] rand_target();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return $urandom();                                     // anywhere
        if (sel == 1) return 32'h3000 + ($urandom_range(0, 16'h1500) & ~32'h0) ; // maybe misaligned
        if (sel == 2) return 32'h44E0;
        return 32'h3000 + ({$urandom_range(0, 32'h04E0 >> 2), 2'b00} & 32'hFFFF_FFFC) * 1;
    endfunction

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        chk_all("reset", 32'h3000, 32'h0, 1'b1, 5'd0, 1'b0);
        reset = 0;

        //            name        rst stl rv  rpc           jmp exc ert epc           e_pc          e_idpc        nop e_exc bd
        vt.push_back(mk("seq1",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3004,     32'h3000,     0,  0,    0));
        vt.push_back(mk("seq2",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3008,     32'h3004,     0,  0,    0));
        vt.push_back(mk("br",     0,  0,  1,  32'h3040,     1,  0,  0,  32'h0,        32'h3040,     32'h3008,     0,  0,    1));
        vt.push_back(mk("tgt",    0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3044,     32'h3040,     0,  0,    0));
        vt.push_back(mk("br2",    0,  0,  1,  32'h3010,     0,  0,  0,  32'h0,        32'h3010,     32'h3044,     0,  0,    0));
        vt.push_back(mk("stl1",   0,  1,  1,  32'h3080,     1,  0,  0,  32'h0,        32'h3010,     32'h3044,     0,  0,    0));
        vt.push_back(mk("stl2",   0,  1,  1,  32'h3080,     1,  0,  0,  32'h0,        32'h3010,     32'h3044,     0,  0,    0));
        vt.push_back(mk("stl3",   0,  1,  1,  32'h3080,     1,  0,  0,  32'h0,        32'h3010,     32'h3044,     0,  0,    0));
        vt.push_back(mk("rel1",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3014,     32'h3010,     0,  0,    0));
        vt.push_back(mk("rel2",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3018,     32'h3014,     0,  0,    0));
        vt.push_back(mk("rel3",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h301C,     32'h3018,     0,  0,    0));
        vt.push_back(mk("rel4",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3020,     32'h301C,     0,  0,    0));
        vt.push_back(mk("exc",    0,  1,  1,  32'h3080,     1,  1,  1,  32'h3000,     32'h4180,     32'h0,        1,  0,    0));
        vt.push_back(mk("hdl",    0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h4184,     32'h4180,     0,  0,    0));
        vt.push_back(mk("eret",   0,  0,  1,  32'h3080,     0,  0,  1,  32'h3024,     32'h3024,     32'h0,        1,  0,    0));
        vt.push_back(mk("ret1",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3028,     32'h3024,     0,  0,    0));
        vt.push_back(mk("mis",    0,  0,  1,  32'h3002,     0,  0,  0,  32'h0,        32'h3002,     32'h3028,     0,  0,    0));
        vt.push_back(mk("hi",     0,  0,  1,  32'h5000,     1,  0,  0,  32'h0,        32'h5000,     32'h3002,     1,  4,    1));
        vt.push_back(mk("hiF",    0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h5004,     32'h5000,     1,  4,    0));
        vt.push_back(mk("rstbr",  1,  1,  1,  32'h3100,     1,  0,  0,  32'h0,        32'h3000,     32'h0,        1,  0,    0));
        vt.push_back(mk("post",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3004,     32'h3000,     0,  0,    0));
        vt.push_back(mk("last",   0,  0,  1,  32'h44E0,     0,  0,  0,  32'h0,        32'h44E0,     32'h3004,     0,  0,    0));
        vt.push_back(mk("lastOK", 0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h44E4,     32'h44E0,     0,  0,    0));
        vt.push_back(mk("pastL",  0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h44E8,     32'h44E4,     1,  4,    0));
        vt.push_back(mk("low",    0,  0,  1,  32'h2FFC,     0,  0,  0,  32'h0,        32'h2FFC,     32'h44E8,     1,  4,    0));
        vt.push_back(mk("lowF",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3000,     32'h2FFC,     1,  4,    0));
        vt.push_back(mk("base",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h3004,     32'h3000,     0,  0,    0));
        vt.push_back(mk("top",    0,  0,  1,  32'hFFFF_FFFC,0,  0,  0,  32'h0,        32'hFFFF_FFFC,32'h3004,     0,  0,    0));
        vt.push_back(mk("wrap",   0,  0,  0,  32'h0,        0,  0,  0,  32'h0,        32'h0,        32'hFFFF_FFFC,1,  4,    0));
        vt.push_back(mk("zero",   0,  0,  0,  32'h0,        1,  0,  0,  32'h0,        32'h4,        32'h0,        1,  4,    1));
        vt.push_back(mk("stlEr",  0,  1,  0,  32'h0,        0,  0,  1,  32'h3000,     32'h4,        32'h0,        1,  4,    1));

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; stall = vt[i].stl; redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc; id_is_jump = vt[i].jmp; exc_req = vt[i].exc;
            eret_req = vt[i].ert; epc = vt[i].epc_v;
            tick();
            chk_all(vt[i].name, vt[i].e_pc, vt[i].e_idpc, vt[i].e_nop, vt[i].e_exc, vt[i].e_bd);
        end

        // ---------------- randomized run against the model ----------------
        idle_inputs();
        reset = 1;
        model_step();
        tick();
        chk_all("rnd_rst", m_pc, m_idpc, (m_instr == 32'h0), m_exc, m_bd);
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            exc_req        = ($urandom_range(0, 29) == 0);
            stall          = ($urandom_range(0, 4) == 0);
            eret_req       = ($urandom_range(0, 19) == 0);
            epc            = rand_target();
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_pc    = rand_target();
            id_is_jump     = redirect_valid ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            model_step();
            tick();
            chk("rnd.pc",       pc,                  m_pc);
            chk("rnd.id_pc",    id_pc,               m_idpc);
            chk("rnd.id_instr", id_instr,            m_instr);
            chk("rnd.id_pc8",   id_pc8,              m_idpc + 32'd8);
            chk("rnd.id_exc",   {27'd0, id_exccode}, {27'd0, m_exc});
            chk("rnd.id_bd",    {31'd0, id_bd},      {31'd0, m_bd});
            $display("[TB] rnd%0d pc=%h id_pc=%h exc=%0d bd=%0b", n, pc, id_pc, id_exccode, id_bd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_if_fetch_stage

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS CPU. Owns the program counter, drives the fetch address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It handles stalls, branch/jump redirects with a delay slot, exception entry to the handler at 0x0000_4180, and `eret` return. It also flags fetch-address exceptions before they reach decode.

## Interface

Parameters:
- `TEXT_BASE`, 32'h0000_3000: reset PC and first valid fetch address.
- `HANDLER_PC`, 32'h0000_4180: exception entry address.
- `TEXT_LAST`, 32'h0000_44E0: last valid fetch word address (inclusive).

Ports (clock and reset first):
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC and IF/ID (load-use or MDU hazard).
- `redirect_valid` in 1: branch taken or jump in ID; load `redirect_pc`.
- `redirect_pc` in 32: branch/jump target.
- `id_is_jump` in 1: ID holds any branch or jump, taken or not; marks the delay slot.
- `exc_req` in 1: exception or interrupt taken in a later stage.
- `eret_req` in 1: `eret` in ID.
- `epc` in 32: return address from CP0.
- `pc` out 32: fetch address to instruction memory.
- `instr_in` in 32: instruction word from memory, combinational on `pc`.
- `id_instr` out 32: IF/ID instruction.
- `id_pc` out 32: IF/ID PC.
- `id_pc8` out 32: `id_pc + 8`, the link value.
- `id_exccode` out 5: 0 = none, 4 = AdEL (fetch).
- `id_bd` out 1: the IF/ID instruction is in a branch delay slot.

## Operation

- Fetch check is combinational on `pc`. A fetch error exists if `pc[1:0] != 0`, `pc < TEXT_BASE`, or `pc > TEXT_LAST`.
  - On a fetch error, IF/ID captures `instr` = 32'h0 (nop) and `exccode` = 4, ignoring `instr_in`.
  - Otherwise IF/ID captures `instr_in` with `exccode` = 0.
- Next-state priority, highest first:
  1. `reset`:
     - `pc` ← `TEXT_BASE`.
     - IF/ID ← `instr` 0, `pc` 0, `exccode` 0, `bd` 0.
  2. `exc_req`:
     - `pc` ← `HANDLER_PC`.
     - IF/ID flushed to the reset values. This overrides `stall`.
  3. `stall`: `pc` and IF/ID hold. Any `redirect_valid` or `eret_req` is ignored this cycle; ID re-presents it.
  4. `eret_req`:
     - `pc` ← `epc`.
     - IF/ID flushed, because `eret` has no delay slot.
  5. `redirect_valid`:
     - `pc` ← `redirect_pc`.
     - IF/ID captures the current fetch (the delay slot) normally.
  6. Default:
     - `pc` ← `pc + 4`.
     - IF/ID captures the current fetch.
- `id_bd` ← `id_is_jump` whenever IF/ID captures (cases 5 and 6). It is 0 on flush and holds on stall.
- `id_pc8` = `id_pc + 8`, combinational, modulo 2^32.
- The PC adder wraps modulo 2^32 with no saturation. Out-of-range PCs are reported through `exccode`, never blocked.
- A misaligned `redirect_pc` or `epc` is accepted into `pc`. It faults on the following capture.

## Timing

- `pc` is registered. `instr_in` is valid in the same cycle. IF/ID updates on the same edge that advances `pc`, giving one cycle of latency from `pc` to `id_*`.
- Redirect latency: `redirect_valid` sampled at edge N gives `pc` = target after N. The delay-slot instruction appears in ID after N, and the target reaches ID after N+1.
- `exc_req` sampled at edge N gives `pc` = 0x4180 and a nop in ID after N. The handler's first word reaches ID after N+1.
- Reset values of outputs: `pc` = 0x0000_3000, `id_instr` = 0, `id_pc` = 0, `id_pc8` = 8, `id_exccode` = 0, `id_bd` = 0.
- A reset asserted mid-stall or mid-redirect overrides everything on that edge.

## Structure

- Shared package `mips_pkg`:
  - Constants `TEXT_BASE`, `HANDLER_PC`, `TEXT_LAST`, `EXC_ADEL` = 5'd4, `EXC_NONE` = 5'd0, `NOP` = 32'h0.
  - The IF/ID bundle struct: `instr`, `pc`, `exccode`, `bd`.
- One sub-module: `fetch_addr_check`, which is combinational and maps `pc` to `{err, exccode}`. It is reused by the data-memory AdEL/AdES logic.

## Test plan

1. Reset, then 4 free-running cycles → `pc` = 3000, 3004, 3008, 300C; `id_pc` lags by one cycle; `id_pc8` = `id_pc` + 8.
2. `redirect_valid` with target 0x3040 and `id_is_jump` = 1 at `pc` = 0x3008 → ID gets the 0x3008 word with `bd` = 1, then 0x3040 with `bd` = 0.
3. `stall` for 3 cycles at `pc` = 0x3010, with `redirect_valid` also high → `pc` and `id_*` are frozen and the redirect is ignored. After release, normal flow resumes.
4. `exc_req` together with `stall` at `pc` = 0x3020 → next `pc` = 0x4180, `id_instr` = 0, `bd` = 0. Then `eret_req` with `epc` = 0x3024 → `pc` = 0x3024 and ID is flushed.
5. Redirect to 0x3002, then to 0x5000 → each capture gives `id_instr` = 0 with `id_exccode` = 4.
6. `reset` asserted during a redirect cycle → `pc` = 0x3000 and all `id_*` outputs at their reset values.
